uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter, the successor to the fixed 8N1 transmitter used by the sniffer's serial dump path.
- Configurable data width, parity mode, stop-bit count and baud divider.
- An internal FIFO buffers sniffed bytes, so the capture logic can push bursts without tracking per-byte busy.
- Frames go out back-to-back with no idle gap while the FIFO is non-empty.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate.
- CLOCK_DIV, CLK_FREQ/BAUD_RATE (integer division): clocks per bit. Must be >= 2.
- DATA_BITS, 8: data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries, power of two, >= 2.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- in_data, input, DATA_BITS: word to enqueue.
- in_valid, input, 1: enqueue request.
- in_ready, output, 1: FIFO can accept a word.
- tx_serial, output, 1: UART line; idles high.
- tx_busy, output, 1: a frame is in progress.
- tx_done, output, 1: one-cycle pulse at the end of each frame.
- fifo_count, output, $clog2(FIFO_DEPTH+1): current occupancy.

Behaviour:
- Reset: clk is the single clock and rst is an asynchronous active-high reset. While rst is high: tx_serial=1, tx_busy=0, tx_done=0, in_ready=1, fifo_count=0, state=IDLE, FIFO pointers=0.
  - Reset mid-frame aborts the frame immediately. The line returns high asynchronously and all FIFO contents are discarded.
- Enqueue:
  - A word is written when in_valid && in_ready at a clock edge.
  - in_ready = (fifo_count < FIFO_DEPTH), registered-free and derived from count only; there is no bypass when full.
  - in_valid while full is ignored and the word is dropped. The source must honour in_ready.
  - A push and a pop in the same cycle leave fifo_count unchanged. This is legal at any occupancy except a push when full.
- State machine IDLE -> START -> DATA -> PARITY -> STOP -> (START | IDLE):
  - IDLE: tx_serial=1. If the FIFO is non-empty, pop the head into the shift register, state<=START, tx_serial<=0, baud counter<=0, tx_busy<=1.
  - START: hold 0 for CLOCK_DIV cycles.
  - DATA: bit i = word[i], i = 0..DATA_BITS-1. Each bit is held for CLOCK_DIV cycles.
  - PARITY: skipped when PARITY=0. Odd parity = ~^word; even parity = ^word, over the DATA_BITS bits only. Held for CLOCK_DIV cycles.
  - STOP: line high for STOP_BITS*CLOCK_DIV cycles.
  - On the last STOP cycle, tx_done pulses high for exactly one cycle (the following cycle).
    - If the FIFO is non-empty at that edge, pop the next word and enter START directly. tx_serial goes 1->0 with zero idle cycles, and tx_busy stays 1.
    - Otherwise go to IDLE with tx_busy<=0.
- Timing: a frame is exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLOCK_DIV cycles, measured from the tx_serial falling edge to the next possible falling edge.
- Latency: a word pushed at edge N into an empty FIFO while IDLE is popped at edge N+1. tx_serial is low from edge N+1.
- The baud counter width is $clog2(CLOCK_DIV). It wraps to 0 at CLOCK_DIV-1 with no drift across bits.
- in_data is sampled only at enqueue. The shift register is not affected by FIFO writes during a frame.

Optional Feature:
- Macro UART_TX_FIFO_CTS_EN.
- When defined:
  - Adds input cts_n (1 bit, active-low clear-to-send, synchronised internally through a 2-flop synchroniser).
  - A pop, whether from IDLE or back-to-back after STOP, occurs only when the synchronised cts_n==0.
  - While the synchronised cts_n==1 with a non-empty FIFO, the block waits in IDLE with tx_serial=1 and tx_busy=0.
  - Deasserting CTS mid-frame does not interrupt the current frame.
- When undefined: there is no cts_n port, and pops depend only on FIFO occupancy.

Test Plan:
- Defaults changed to CLOCK_DIV=10, 8N1: push 0xA5 -> start low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then stop high 10 cycles. tx_done pulses once, 100 cycles after the falling edge.
- PARITY=2, DATA_BITS=7, STOP_BITS=2: push 0x03 -> parity bit 0, stop high 20 cycles, frame 110 cycles. With PARITY=1 the parity bit is 1.
- Push 3 words on consecutive cycles -> three contiguous frames with no idle gap, tx_busy continuously high, three tx_done pulses 100 cycles apart. fifo_count sequence is 1, 1, 2, then it decrements per frame.
- FIFO_DEPTH=4, hold in_valid for 6 cycles while busy -> in_ready drops once count reaches 4. Exactly 5 words are transmitted (1 in flight plus 4 queued), and the extra word is dropped.
- Assert rst mid DATA bit 3 -> tx_serial=1, tx_busy=0 and fifo_count=0 asynchronously. After release, with no push, the line stays high.
- With UART_TX_FIFO_CTS_EN: cts_n=1 and push 0x55 -> no start bit. Drop cts_n -> start bit begins 3 cycles later (2-flop sync plus pop edge).

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by an internal FIFO; frames go out back-to-back while data is queued.
// Optional flow control: define UART_TX_FIFO_CTS_EN to add an active-low cts_n input gating each pop.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int CLOCK_DIV  = CLK_FREQ / BAUD_RATE,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_BITS-1:0]            in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
`ifdef UART_TX_FIFO_CTS_EN
  input  logic                            cts_n,
`endif
  output logic                            tx_serial,
  output logic                            tx_busy,
  output logic                            tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLOCK_DIV);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 can_pop;
  logic                 cts_ok;
  logic [DATA_BITS-1:0] head;

  logic [2:0]           state;
  logic [DW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 baud_end;
  logic                 last_stop;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~^w : ^w;
  endfunction

`ifdef UART_TX_FIFO_CTS_EN
  logic cts_meta;
  logic cts_sync;

  // Resets to "not clear" so nothing leaves before the synchroniser has seen the real input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      cts_meta <= cts_n;
      cts_sync <= cts_meta;
    end
  end

  assign cts_ok = ~cts_sync;
`else
  assign cts_ok = 1'b1;
`endif

  assign in_ready  = (fifo_count < DEPTH_C);
  assign push      = in_valid && in_ready;
  assign head      = mem[rd_ptr];
  assign can_pop   = (fifo_count != '0) && cts_ok;
  assign baud_end  = (baud_cnt == DIV_LAST);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign pop       = can_pop && ((state == S_IDLE) ||
                                 ((state == S_STOP) && baud_end && last_stop));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != S_IDLE) begin
        baud_cnt <= baud_end ? '0 : baud_cnt + DW'(1);
      end
      case (state)
        S_IDLE: begin
          tx_serial <= 1'b1;
          if (pop) begin
            shift_reg <= head;
            par_bit   <= parity_of(head);
            state     <= S_START;
            tx_serial <= 1'b0;
            baud_cnt  <= '0;
            tx_busy   <= 1'b1;
          end
        end
        S_START: begin
          if (baud_end) begin
            state     <= S_DATA;
            bit_idx   <= '0;
            tx_serial <= shift_reg[0];
          end
        end
        // shift_reg[0] is on the line; the next bit is always shift_reg[1].
        S_DATA: begin
          if (baud_end) begin
            if (bit_idx == BIT_LAST) begin
              if (PARITY != 0) begin
                state     <= S_PARITY;
                tx_serial <= par_bit;
              end else begin
                state     <= S_STOP;
                stop_idx  <= 1'b0;
                tx_serial <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + BW'(1);
              tx_serial <= shift_reg[1];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            state     <= S_STOP;
            stop_idx  <= 1'b0;
            tx_serial <= 1'b1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            if (last_stop) begin
              tx_done <= 1'b1;
              if (pop) begin
                shift_reg <= head;
                par_bit   <= parity_of(head);
                state     <= S_START;
                tx_serial <= 1'b0;
              end else begin
                state   <= S_IDLE;
                tx_busy <= 1'b0;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (8N1 depth 4, 7E2, 7O2), all at 10 clocks per bit.
// Frame vectors are table driven; back-to-back, overflow, reset and CTS sequences are hand written.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] in_data_a;
  logic [6:0] in_data_b;
  logic [6:0] in_data_c;
  logic       in_valid_a, in_valid_b, in_valid_c;
  logic       in_ready_a, in_ready_b, in_ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [2:0] count_a;
  logic [4:0] count_b;
  logic [4:0] count_c;
`ifdef UART_TX_FIFO_CTS_EN
  logic       cts_n_a, cts_n_b, cts_n_c;
`endif

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_fifo #(.CLOCK_DIV(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
`ifdef UART_TX_FIFO_CTS_EN
    .cts_n(cts_n_a),
`endif
    .tx_serial(tx_a), .tx_busy(busy_a), .tx_done(done_a), .fifo_count(count_a));

  uart_tx_fifo #(.CLOCK_DIV(10), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
`ifdef UART_TX_FIFO_CTS_EN
    .cts_n(cts_n_b),
`endif
    .tx_serial(tx_b), .tx_busy(busy_b), .tx_done(done_b), .fifo_count(count_b));

  uart_tx_fifo #(.CLOCK_DIV(10), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
`ifdef UART_TX_FIFO_CTS_EN
    .cts_n(cts_n_c),
`endif
    .tx_serial(tx_c), .tx_busy(busy_c), .tx_done(done_c), .fifo_count(count_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Frame bit 0 is the start bit, followed by data LSB first, optional parity, then stop bits.
  typedef struct {
    int          inst;
    logic [8:0]  word;
    int          nbits;
    logic [11:0] frame;
  } vec_t;

  vec_t vecs[6];

  function automatic logic get_tx(input int inst);
    case (inst)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic get_done(input int inst);
    case (inst)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a falling clock edge; the word is pushed at the next rising edge.
  task automatic applyStimulus(input int inst, input logic [8:0] word);
    case (inst)
      0:       begin in_valid_a = 1'b1; in_data_a = word[7:0]; end
      1:       begin in_valid_b = 1'b1; in_data_b = word[6:0]; end
      default: begin in_valid_c = 1'b1; in_data_c = word[6:0]; end
    endcase
    @(negedge clk);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_valid_c = 1'b0;
  endtask

  task automatic captureFrame(input int inst, input int nbits, output logic [11:0] frame, output int done_at);
    int w;
    w = 0;
    frame = '0;
    done_at = -1;
    while (get_tx(inst) !== 1'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    checkOutput("frame_start", {31'd0, get_tx(inst)}, 32'd0);
    checkOutput("busy_at_start", {31'd0, get_busy(inst)}, 32'd1);
    for (int c = 1; c <= nbits * 10 + 5; c++) begin
      @(negedge clk);
      if ((c % 10) == 5 && (c / 10) < nbits) frame[c / 10] = get_tx(inst);
      if (get_done(inst) && done_at < 0) done_at = c;
    end
  endtask

  initial begin
    logic [11:0] frame;
    int          done_at;
    int          dones[4];
    int          n_done;
    logic        flag;
    logic [7:0]  words[6];
    logic [7:0]  rx[5];
    int          exp_cnt[6];
    logic        exp_rdy[6];

    vecs[0] = '{0, 9'h0A5,  10, 12'h34A};
    vecs[1] = '{0, 9'h03C,  10, 12'h278};
    vecs[2] = '{1, 9'h003,  11, 12'h606};
    vecs[3] = '{2, 9'h003,  11, 12'h706};
    vecs[4] = '{1, 9'h051,  11, 12'h7A2};
    vecs[5] = '{2, 9'h051,  11, 12'h6A2};

    rst = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
    in_data_a = '0; in_data_b = '0; in_data_c = '0;
`ifdef UART_TX_FIFO_CTS_EN
    cts_n_a = 1'b0; cts_n_b = 1'b0; cts_n_c = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", {31'd0, tx_a}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rst_done", {31'd0, done_a}, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready_a}, 32'd1);
    checkOutput("rst_count", {29'd0, count_a}, 32'd0);
    checkOutput("rst_tx_b", {31'd0, tx_b}, 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].inst, vecs[i].word);
      captureFrame(vecs[i].inst, vecs[i].nbits, frame, done_at);
      checkOutput($sformatf("frame_bits_%0d", i), {20'd0, frame}, {20'd0, vecs[i].frame});
      checkOutput($sformatf("frame_len_%0d", i), done_at, vecs[i].nbits * 10);
    end

    // Three words on consecutive cycles: contiguous frames, tx_done every 100 cycles.
    in_valid_a = 1'b1; in_data_a = 8'h11;
    @(negedge clk); checkOutput("b2b_count0", {29'd0, count_a}, 32'd1); in_data_a = 8'h22;
    @(negedge clk); checkOutput("b2b_count1", {29'd0, count_a}, 32'd1); in_data_a = 8'h33;
    @(negedge clk); checkOutput("b2b_count2", {29'd0, count_a}, 32'd2); in_valid_a = 1'b0;
    checkOutput("b2b_start", {31'd0, tx_a}, 32'd0);
    n_done = 0;
    flag = 1'b0;
    for (int t = 2; t <= 305; t++) begin
      @(negedge clk);
      if (done_a) begin
        if (n_done < 4) dones[n_done] = t;
        n_done++;
      end
      if (t < 300 && !busy_a) flag = 1'b1;
      if (t == 100) begin
        checkOutput("b2b_gap1_tx", {31'd0, tx_a}, 32'd0);
        checkOutput("b2b_gap1_count", {29'd0, count_a}, 32'd1);
      end
      if (t == 200) begin
        checkOutput("b2b_gap2_tx", {31'd0, tx_a}, 32'd0);
        checkOutput("b2b_gap2_count", {29'd0, count_a}, 32'd0);
      end
      if (t == 301) begin
        checkOutput("b2b_end_busy", {31'd0, busy_a}, 32'd0);
        checkOutput("b2b_end_tx", {31'd0, tx_a}, 32'd1);
      end
    end
    checkOutput("b2b_done_count", n_done, 3);
    checkOutput("b2b_done0", dones[0], 100);
    checkOutput("b2b_done1", dones[1], 200);
    checkOutput("b2b_done2", dones[2], 300);
    checkOutput("b2b_busy_drop", {31'd0, flag}, 32'd0);
    repeat (5) @(negedge clk);

    // Depth-4 overflow: six held pushes, one in flight plus four queued, sixth dropped.
    words   = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    exp_cnt = '{1, 1, 2, 3, 4, 4};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    in_valid_a = 1'b1; in_data_a = words[0];
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ovf_count%0d", k), {29'd0, count_a}, exp_cnt[k-1]);
      checkOutput($sformatf("ovf_ready%0d", k), {31'd0, in_ready_a}, {31'd0, exp_rdy[k-1]});
      if (k < 6) in_data_a = words[k];
    end
    in_valid_a = 1'b0;
    n_done = 0;
    flag = 1'b0;
    for (int k = 0; k < 5; k++) rx[k] = '0;
    for (int t = 5; t <= 560; t++) begin
      @(negedge clk);
      if ((t % 10) == 5 && t < 500 && ((t % 100) / 10) >= 1 && ((t % 100) / 10) <= 8)
        rx[t / 100][((t % 100) / 10) - 1] = tx_a;
      if (done_a) n_done++;
      if (t >= 500 && !tx_a) flag = 1'b1;
    end
    for (int k = 0; k < 5; k++) checkOutput($sformatf("ovf_rx%0d", k), {24'd0, rx[k]}, {24'd0, words[k]});
    checkOutput("ovf_done_count", n_done, 5);
    checkOutput("ovf_no_sixth", {31'd0, flag}, 32'd0);
    checkOutput("ovf_final_count", {29'd0, count_a}, 32'd0);

`ifdef UART_TX_FIFO_CTS_EN
    // CTS held off: word waits; release starts the frame after sync plus pop edge.
    cts_n_a = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(0, 9'h055);
    flag = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (!tx_a || busy_a) flag = 1'b1;
    end
    checkOutput("cts_hold_line", {31'd0, flag}, 32'd0);
    checkOutput("cts_hold_count", {29'd0, count_a}, 32'd1);
    cts_n_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("cts_tx_t2", {31'd0, tx_a}, 32'd1);
    @(negedge clk);
    checkOutput("cts_tx_t3", {31'd0, tx_a}, 32'd0);
    repeat (110) @(negedge clk);
    checkOutput("cts_drained", {29'd0, count_a}, 32'd0);
`endif

    // Asynchronous reset during data bit 3 discards the frame and the queued word.
    applyStimulus(0, 9'h0A5);
    applyStimulus(0, 9'h0FF);
    checkOutput("rstmid_count_before", {29'd0, count_a}, 32'd1);
    repeat (43) @(negedge clk);
    checkOutput("rstmid_busy_before", {31'd0, busy_a}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstmid_tx", {31'd0, tx_a}, 32'd1);
    checkOutput("rstmid_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rstmid_count", {29'd0, count_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    flag = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!tx_a || busy_a) flag = 1'b1;
    end
    checkOutput("rstmid_line_idle", {31'd0, flag}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
